// File: rtl/press_pkg.sv
// Shared types and default timing constants for the press classifier.
package press_pkg;

    localparam int DEB_CYCLES_DEF  = 4;
    localparam int LONG_CYCLES_DEF = 16;
    localparam int GAP_CYCLES_DEF  = 12;
    localparam int CNT_W_DEF       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        HOLD2 = 2'd3
    } press_state_t;

endpackage

// File: rtl/din_sync_debounce.sv
// Two-flop synchronizer and counting debouncer producing filtered rise/fall pulses.
// Latency: raw edge to filtered edge is 2 + DEB_CYCLES clock edges.
// Backpressure: none; rise and fall are single-cycle pulses with no handshake.
module din_sync_debounce
    import press_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic filt,
    output logic rise,
    output logic fall
);

    logic             s1;
    logic             s2;
    logic             filt_d;
    logic [CNT_W-1:0] deb_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            filt    <= 1'b0;
            filt_d  <= 1'b0;
            deb_cnt <= '0;
        end else begin
            s1     <= din;
            s2     <= s1;
            filt_d <= filt;
            if (s2 == filt) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                // The count would reach DEB_CYCLES this cycle: accept the new level.
                filt    <= ~filt;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign rise = filt & ~filt_d;
    assign fall = ~filt & filt_d;

endmodule

// File: rtl/press_classifier.sv
// Debounced push-button classifier: short/long strobes plus press width; PRESS_DOUBLE_EN adds double-press detection.
// Latency: strobe one cycle after the filtered fall (or gap timeout), i.e. 2 + DEB_CYCLES + 1 edges after release.
// Backpressure: none; strobes are single-cycle fire-and-forget, o_busy flags an in-progress classification.
module press_classifier
    import press_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_din,
    output logic             o_short,
    output logic             o_long,
    output logic             o_double,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_width
);

    press_state_t     state;
    press_state_t     state_nxt;
    logic             filt;
    logic             rise;
    logic             fall;
    logic             is_long;
    logic [CNT_W-1:0] width_cnt;
    logic             short_nxt;
    logic             long_nxt;
    logic             width_ld;

    din_sync_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_din (
        .clk  (i_clk),
        .rst  (i_rst),
        .din  (i_din),
        .filt (filt),
        .rise (rise),
        .fall (fall)
    );

    // Counts filtered-high cycles, starting at 1 on the rise and saturating.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            width_cnt <= '0;
        end else if (rise) begin
            width_cnt <= CNT_W'(1);
        end else if (filt && (width_cnt != '1)) begin
            width_cnt <= width_cnt + 1'b1;
        end
    end

    assign is_long = (width_cnt >= CNT_W'(LONG_CYCLES));

`ifdef PRESS_DOUBLE_EN
    logic [CNT_W-1:0] gap_cnt;
    logic             gap_clr;
    logic             gap_done;
    logic             double_nxt;

    assign gap_done = (gap_cnt == CNT_W'(GAP_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gap_cnt <= '0;
        end else if (gap_clr) begin
            gap_cnt <= '0;
        end else if ((state == GAP) && (gap_cnt != '1)) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_double <= 1'b0;
        end else begin
            o_double <= double_nxt;
        end
    end
`else
    logic unused_gap;
    assign unused_gap = (GAP_CYCLES != 0);
    assign o_double   = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rise) state_nxt = PRESS;
            end
            PRESS: begin
                if (fall) begin
`ifdef PRESS_DOUBLE_EN
                    state_nxt = is_long ? IDLE : GAP;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef PRESS_DOUBLE_EN
            GAP: begin
                // A second press in the same cycle as the timeout still counts as a double.
                if (rise)          state_nxt = HOLD2;
                else if (gap_done) state_nxt = IDLE;
            end
            HOLD2: begin
                if (fall) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        width_ld   = 1'b0;
`ifdef PRESS_DOUBLE_EN
        double_nxt = 1'b0;
        gap_clr    = 1'b0;
`endif
        case (state)
            PRESS: begin
                if (fall) begin
                    width_ld = 1'b1;
                    if (is_long) begin
                        long_nxt = 1'b1;
                    end else begin
`ifdef PRESS_DOUBLE_EN
                        gap_clr = 1'b1;
`else
                        short_nxt = 1'b1;
`endif
                    end
                end
            end
`ifdef PRESS_DOUBLE_EN
            GAP: begin
                if (rise)          double_nxt = 1'b1;
                else if (gap_done) short_nxt  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_short <= 1'b0;
            o_long  <= 1'b0;
            o_width <= '0;
        end else begin
            o_short <= short_nxt;
            o_long  <= long_nxt;
            if (width_ld) o_width <= width_cnt;
        end
    end

    assign o_busy = (state != IDLE);

endmodule
